// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory access controller.
//   mem_size_t  : access size encoding carried on size_i (3 behaves as a word)
//   mem_state_t : bus master FSM states, MEM_ prefixed so they do not collide
//                 with the CPU FSM's own state names
//   byte_swap32 : big-endian CPU word <-> little-lane Avalon word
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUS  = 2'd1,
    MEM_CAPT = 2'd2,
    MEM_RESP = 2'd3
  } mem_state_t;

  // Lane 0 carries the most significant CPU byte, so a word is a plain byte swap.
  function automatic logic [31:0] byte_swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory access controller.
// Ports:
//   size       : access size (mem_size_t encoding, 3 treated as word)
//   addr_lo    : byte offset within the word
//   sign_ext   : loads, 1 = sign-extend, 0 = zero-extend
//   wdata      : right-aligned store value
//   readdata   : raw Avalon read data
//   byteenable : lane mask of the access
//   writedata  : store value placed on its lanes, disabled lanes zero
//   load_val   : extracted and extended load value
//   misaligned : half on odd address or word not on a 4-byte boundary
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane k holds the byte at word address + k (big-endian CPU view).
  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0000_0000;
    load_val   = 32'h0000_0000;
    misaligned = 1'b0;
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    case (mem_size_t'(size))
      MEM_BYTE: begin
        case (addr_lo)
          2'd0: begin byteenable = 4'b0001; writedata = {24'h000000, wdata[7:0]};         byte_s = readdata[7:0];   end
          2'd1: begin byteenable = 4'b0010; writedata = {16'h0000, wdata[7:0], 8'h00};    byte_s = readdata[15:8];  end
          2'd2: begin byteenable = 4'b0100; writedata = {8'h00, wdata[7:0], 16'h0000};    byte_s = readdata[23:16]; end
          default: begin byteenable = 4'b1000; writedata = {wdata[7:0], 24'h000000};      byte_s = readdata[31:24]; end
        endcase
        if (sign_ext) begin
          load_val = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_val = {24'h000000, byte_s};
        end
      end
      MEM_HALF: begin
        misaligned = addr_lo[0];
        // The high CPU byte sits on the lower lane of the pair.
        if (addr_lo[1]) begin
          byteenable = 4'b1100;
          writedata  = {wdata[7:0], wdata[15:8], 16'h0000};
          half_s     = {readdata[23:16], readdata[31:24]};
        end else begin
          byteenable = 4'b0011;
          writedata  = {16'h0000, wdata[7:0], wdata[15:8]};
          half_s     = {readdata[7:0], readdata[15:8]};
        end
        if (sign_ext) begin
          load_val = {{16{half_s[15]}}, half_s};
        end else begin
          load_val = {16'h0000, half_s};
        end
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
        byteenable = 4'b1111;
        writedata  = byte_swap32(wdata);
        load_val   = byte_swap32(readdata);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Avalon-MM bus master between the CPU datapath and external memory.
// Accepts one request at a time, holds the bus phase through waitrequest,
// steers byte lanes and provides busy_o as the CPU stall source.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req_i .. wdata_i     : CPU request (strobe, direction, address, size, extend, store data)
//   rdata_o              : extended load result, held until the next load completes
//   done_o, err_o        : completion pulse, misaligned flag pulsing with done_o
//   busy_o               : high while a bus transfer is in flight
//   wait_cycles_o        : saturating count of waitrequest cycles in the current/last transfer
//   address .. readdata  : Avalon-MM master interface
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [WAIT_CNT_W-1:0] wait_cycles_o,
  output logic [31:0]           address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);

  mem_state_t            state_r, state_s;
  logic                  accept_s, we_nxt_s;
  logic                  we_l_r, sign_l_r;
  logic [1:0]            addr_lo_r, size_l_r;
  logic [1:0]            al_size_s, al_addr_s;
  logic                  al_sign_s;
  logic [3:0]            be_s;
  logic [31:0]           wd_s, load_s;
  logic                  mis_s;
  logic [WAIT_CNT_W-1:0] wait_r;
  logic [31:0]           rdata_r, address_r, wd_r;
  logic [3:0]            be_r;
  logic                  done_r, err_r, busy_r, read_r, write_r;

  // The aligner sees the incoming request while accepting and the latched one afterwards.
  always_comb begin
    if (state_r == MEM_IDLE || state_r == MEM_RESP) begin
      al_size_s = size_i;
      al_addr_s = addr_i[1:0];
      al_sign_s = sign_ext_i;
    end else begin
      al_size_s = size_l_r;
      al_addr_s = addr_lo_r;
      al_sign_s = sign_l_r;
    end
  end

  mem_lane_align u_align (
    .size       (al_size_s),
    .addr_lo    (al_addr_s),
    .sign_ext   (al_sign_s),
    .wdata      (wdata_i),
    .readdata   (readdata),
    .byteenable (be_s),
    .writedata  (wd_s),
    .load_val   (load_s),
    .misaligned (mis_s)
  );

  // Next-state decode; a request is only taken in IDLE or RESP.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      MEM_IDLE: begin
        if (req_i) begin
          accept_s = 1'b1;
        end else begin
          state_s = MEM_IDLE;
        end
      end
      MEM_BUS: begin
        if (waitrequest) begin
          state_s = MEM_BUS;
        end else if (we_l_r) begin
          state_s = MEM_RESP;
        end else begin
          state_s = MEM_CAPT;
        end
      end
      MEM_CAPT: state_s = MEM_RESP;
      MEM_RESP: begin
        if (req_i) begin
          accept_s = 1'b1;
        end else begin
          state_s = MEM_IDLE;
        end
      end
      default: state_s = MEM_IDLE;
    endcase
    // Misaligned requests skip the bus and report straight away.
    if (accept_s) begin
      state_s = mis_s ? MEM_RESP : MEM_BUS;
    end else begin
      state_s = state_s;
    end
    we_nxt_s = accept_s ? we_i : we_l_r;
  end

  // State, latched request and bus-phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= MEM_IDLE;
      we_l_r    <= 1'b0;
      sign_l_r  <= 1'b0;
      addr_lo_r <= 2'b00;
      size_l_r  <= 2'b00;
      address_r <= 32'h0000_0000;
      be_r      <= 4'b0000;
      wd_r      <= 32'h0000_0000;
      wait_r    <= {WAIT_CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        we_l_r    <= we_i;
        sign_l_r  <= sign_ext_i;
        addr_lo_r <= addr_i[1:0];
        size_l_r  <= size_i;
        address_r <= {addr_i[31:2], 2'b00};
        be_r      <= be_s;
        wd_r      <= wd_s;
        wait_r    <= {WAIT_CNT_W{1'b0}};
      end else if (state_r == MEM_BUS && waitrequest && wait_r != {WAIT_CNT_W{1'b1}}) begin
        wait_r <= wait_r + WAIT_CNT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
    end
  end

  // Registered strobes and load result, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      read_r  <= (state_s == MEM_BUS) && !we_nxt_s;
      write_r <= (state_s == MEM_BUS) && we_nxt_s;
      done_r  <= (state_s == MEM_RESP);
      err_r   <= accept_s && mis_s;
      busy_r  <= (state_s == MEM_BUS) || (state_s == MEM_CAPT);
      if (state_r == MEM_CAPT) begin
        rdata_r <= load_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rdata_o       = rdata_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign busy_o        = busy_r;
  assign wait_cycles_o = wait_r;
  assign address       = address_r;
  assign read          = read_r;
  assign write         = write_r;
  assign writedata     = wd_r;
  assign byteenable    = be_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk, reset, req_i, we_i, sign_ext_i, waitrequest;
  logic [31:0] addr_i, wdata_i, readdata;
  logic [1:0]  size_i;
  logic [31:0] rdata_o, address, writedata;
  logic        done_o, err_o, busy_o, read, write;
  logic [7:0]  wait_cycles_o;
  logic [3:0]  byteenable;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.WAIT_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .size_i(size_i), .sign_ext_i(sign_ext_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .wait_cycles_o(wait_cycles_o), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          sx;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          nw;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; size_i = v.size;
    sign_ext_i = v.sx; wdata_i = v.wdata; readdata = v.rd;
  endtask

  // One complete transaction from request to the cycle after done_o.
  task automatic run_vec(input vec_t v, input int n);
    int bus_cnt = 0, dir_bad = 0, lane_bad = 0, done_at = -1;
    int exp_wait, exp_done;
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    exp_wait = v.exp_err ? 0 : ((v.nw > 255) ? 255 : v.nw);
    exp_done = v.exp_err ? 0 : (v.we ? v.nw + 1 : v.nw + 2);
    @(negedge clk);
    drive(v);
    waitrequest = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_i = 1'b0;
      if (read || write) begin
        bus_cnt++;
        if (read == v.we || write != v.we) dir_bad++;
        if (i == 0) begin
          check($sformatf("v%0d_address", n), address, exp_addr);
          check($sformatf("v%0d_be", n), {28'h0, byteenable}, {28'h0, v.exp_be});
          if (v.we) check($sformatf("v%0d_wd", n), writedata, v.exp_wd);
        end else if (address != exp_addr || byteenable != v.exp_be || (v.we && writedata != v.exp_wd)) begin
          lane_bad++;
        end
      end
      if (done_o) begin
        done_at = i;
        check($sformatf("v%0d_err", n), {31'h0, err_o}, {31'h0, v.exp_err});
        check($sformatf("v%0d_rdata", n), rdata_o, v.exp_rdata);
        check($sformatf("v%0d_wait", n), {24'h0, wait_cycles_o}, exp_wait);
        break;
      end
      waitrequest = (i < v.nw);
    end
    waitrequest = 1'b0;
    check($sformatf("v%0d_done_at", n), done_at, exp_done);
    check($sformatf("v%0d_bus_cycles", n), bus_cnt, v.exp_err ? 0 : v.nw + 1);
    check($sformatf("v%0d_dir", n), dir_bad, 0);
    check($sformatf("v%0d_stable", n), lane_bad, 0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", n), {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    int done_cnt;
    vec_t bb;
    reset = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; size_i = 2'd0;
    sign_ext_i = 1'b0; wdata_i = 32'h0; waitrequest = 1'b0; readdata = 32'h0;

    //             we    addr          sz    sx    wdata         rd            nw   exp_rdata     be      exp_wd        err
    vecs[0]  = '{1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0,        32'h4433_2211, 0,   32'h1122_3344, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0,        32'h80FF_FFFF, 0,   32'hFFFF_FF80, 4'h8, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0,        32'h80FF_FFFF, 0,   32'h0000_0080, 4'h8, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0,        3,   32'h0000_0080, 4'hC, 32'hEFBE_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_1002, 2'd2, 1'b0, 32'h0,        32'hDEAD_BEEF, 0,   32'h0000_0080, 4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h0000_1000, 2'd1, 1'b1, 32'h0,        32'h0000_7F80, 1,   32'hFFFF_807F, 4'h3, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0,        32'h3412_ABCD, 2,   32'h0000_1234, 4'hC, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h0000_4000, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        0,   32'h0000_1234, 4'hF, 32'h7856_3412, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_5001, 2'd1, 1'b0, 32'h0000_1111, 32'h0,        0,   32'h0000_1234, 4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h0000_6002, 2'd0, 1'b0, 32'h1234_56C3, 32'h0,        0,   32'h0000_1234, 4'h4, 32'h00C3_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_7001, 2'd0, 1'b1, 32'h0,        32'h0000_7F00, 0,   32'h0000_007F, 4'h2, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0000_8000, 2'd3, 1'b0, 32'h0,        32'hDDCC_BBAA, 1,   32'hAABB_CCDD, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h0000_9000, 2'd2, 1'b0, 32'h0,        32'h0102_0304, 260, 32'h0403_0201, 4'hF, 32'h0,        1'b0};

    // Reset state
    @(negedge clk);
    check("rst_read", {31'h0, read}, 32'h0);
    check("rst_write", {31'h0, write}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_be_wd", {28'h0, byteenable} | writedata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // Back-to-back: new SB presented while done_o of a word load is high.
    @(negedge clk);
    drive(vecs[0]);
    done_cnt = 0;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (done_o) done_cnt = 1;
    end
    check("b2b_first_done", done_cnt, 1);
    check("b2b_first_rdata", rdata_o, 32'h1122_3344);
    bb = '{1'b1, 32'h0000_3001, 2'd0, 1'b0, 32'h0000_00AA, 32'h0, 0, 32'h0, 4'h2, 32'h0000_AA00, 1'b0};
    drive(bb);
    @(negedge clk);
    check("b2b_write", {31'h0, write}, 32'h1);
    check("b2b_read", {31'h0, read}, 32'h0);
    check("b2b_be", {28'h0, byteenable}, 32'h2);
    check("b2b_wd", writedata, 32'h0000_AA00);
    check("b2b_address", address, 32'h0000_3000);
    req_i = 1'b0;
    @(negedge clk);
    check("b2b_done", {31'h0, done_o}, 32'h1);
    @(negedge clk);

    // Reset in the middle of a stalled read.
    drive(vecs[0]);
    waitrequest = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    check("mid_read_high", {31'h0, read}, 32'h1);
    check("mid_busy_high", {31'h0, busy_o}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_read", {31'h0, read}, 32'h0);
    check("async_write", {31'h0, write}, 32'h0);
    check("async_busy", {31'h0, busy_o}, 32'h0);
    check("async_rdata", rdata_o, 32'h0);
    check("async_wait", {24'h0, wait_cycles_o}, 32'h0);
    check("async_address", address, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o || read || write || busy_o) done_cnt++;
    end
    check("post_reset_idle", done_cnt, 0);
    run_vec(vecs[0], 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
